brch_redirect_ctrl: RTL and testbench

Fetch-side PC and redirect controller for the 16-bit pipeline. It owns the architectural fetch PC and consumes the taken/not-taken signal produced by the branch-condition unit in EX, together with the computed target. On a taken branch or jump it steers fetch to the target, squashes wrong-path instructions in IF/ID and ID/EX, and holds the redirect while instruction memory is busy. It also freezes fetch on HALT and keeps a saturating count of redirects for performance monitoring.

---
 rtl/brch_redirect_ctrl.sv | 110 +++++++++++
 tb/tb_brch_redirect_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/brch_redirect_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// brch_redirect_ctrl : fetch PC owner, branch/jump redirect, squash and HALT
// Rev 1.0
// ---------------------------------------------------------------------------
module brch_redirect_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        BrchOrJmpSig,
    input  logic        ex_valid,
    input  logic [15:0] brch_target,
    input  logic        fetch_stall,
    input  logic        imem_busy,
    input  logic        halt,
    output logic [15:0] PC,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        redirect_pending,
    output logic        halted,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HLT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] tgt_q, tgt_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cnt_inc;

    logic take;
    logic hlt;

    assign take = ex_valid & BrchOrJmpSig;
    assign hlt  = ex_valid & halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= 16'h0000;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        tgt_d            = tgt_q;
        cnt_inc          = 1'b0;
        flush_ifid       = 1'b0;
        flush_idex       = 1'b0;
        redirect_pending = 1'b0;

        case (state_q)
            ST_RUN: begin
                // HALT wins over a simultaneous taken branch: no redirect, no count
                if (hlt) begin
                    state_d    = ST_HLT;
                    flush_ifid = 1'b1;
                end else if (take) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    cnt_inc    = 1'b1;
                    if (imem_busy) begin
                        tgt_d   = brch_target;
                        state_d = ST_PEND;
                    end else begin
                        pc_d = brch_target;
                    end
                end else if (!fetch_stall && !imem_busy) begin
                    pc_d = pc_q + 16'd2;
                end
            end
            ST_PEND: begin
                redirect_pending = 1'b1;
                flush_ifid       = 1'b1;
                if (!imem_busy) begin
                    pc_d    = tgt_q;
                    state_d = ST_RUN;
                end
            end
            ST_HLT: begin
                state_d = ST_HLT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        cnt_d = (cnt_inc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    assign PC           = pc_q;
    assign halted       = (state_q == ST_HLT);
    assign redirect_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_brch_redirect_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_brch_redirect_ctrl : directed self-checking bench for brch_redirect_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_brch_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        BrchOrJmpSig;
    logic        ex_valid;
    logic [15:0] brch_target;
    logic        fetch_stall;
    logic        imem_busy;
    logic        halt;
    logic [15:0] PC;
    logic        flush_ifid;
    logic        flush_idex;
    logic        redirect_pending;
    logic        halted;
    logic [15:0] redirect_cnt;

    int n_chk;
    int n_err;

    brch_redirect_ctrl #(.RESET_PC(16'h0000)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .BrchOrJmpSig     (BrchOrJmpSig),
        .ex_valid         (ex_valid),
        .brch_target      (brch_target),
        .fetch_stall      (fetch_stall),
        .imem_busy        (imem_busy),
        .halt             (halt),
        .PC               (PC),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .redirect_pending (redirect_pending),
        .halted           (halted),
        .redirect_cnt     (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        BrchOrJmpSig = 1'b0;
        ex_valid     = 1'b0;
        brch_target  = 16'h0000;
        fetch_stall  = 1'b0;
        imem_busy    = 1'b0;
        halt         = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic fi, input logic fe,
                               input logic rp, input logic hd);
        check_eq({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, fi});
        check_eq({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, fe});
        check_eq({tag, ".pending"},    {31'd0, redirect_pending}, {31'd0, rp});
        check_eq({tag, ".halted"},     {31'd0, halted}, {31'd0, hd});
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        idle_inputs();
        rst_n = 1'b0;

        // Reset state
        #12;
        check_eq("rst.pc", {16'd0, PC}, 32'h0000);
        check_eq("rst.cnt", {16'd0, redirect_cnt}, 32'h0000);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential fetch from RESET_PC
        tick(); check_eq("seq.pc1", {16'd0, PC}, 32'h0002);
        check_flags("seq", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); check_eq("seq.pc2", {16'd0, PC}, 32'h0004);
        tick(); check_eq("seq.pc3", {16'd0, PC}, 32'h0006);
        repeat (5) tick();
        check_eq("seq.pc8", {16'd0, PC}, 32'h0010);

        // Taken branch, imem free
        ex_valid = 1'b1; BrchOrJmpSig = 1'b1; brch_target = 16'h0040;
        #1;
        check_flags("take", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle_inputs();
        check_eq("take.pc", {16'd0, PC}, 32'h0040);
        check_eq("take.cnt", {16'd0, redirect_cnt}, 32'h0001);
        #1;
        check_flags("take.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Redirect while imem busy
        ex_valid = 1'b1; BrchOrJmpSig = 1'b1; brch_target = 16'h0100; imem_busy = 1'b1;
        #1;
        check_flags("busy.resolve", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        // EX content during PEND must be ignored, including a halt
        ex_valid = 1'b1; BrchOrJmpSig = 1'b1; halt = 1'b1; brch_target = 16'h0999;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_flags("pend", 1'b1, 1'b0, 1'b1, 1'b0);
            check_eq("pend.pc", {16'd0, PC}, 32'h0040);
            tick();
            ex_valid = 1'b0; BrchOrJmpSig = 1'b0; halt = 1'b0;
        end
        imem_busy = 1'b0;
        #1;
        check_flags("pend.release", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("pend.pc_tgt", {16'd0, PC}, 32'h0100);
        check_eq("pend.cnt", {16'd0, redirect_cnt}, 32'h0002);
        check_flags("pend.run", 1'b0, 1'b0, 1'b0, 1'b0);

        // Not-taken, stall, take over stall, wrap, busy hold
        ex_valid = 1'b1; BrchOrJmpSig = 1'b0; brch_target = 16'h0777;
        #1;
        check_flags("nt", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("nt.pc", {16'd0, PC}, 32'h0102);
        ex_valid = 1'b0; fetch_stall = 1'b1;
        tick(); check_eq("stall.pc1", {16'd0, PC}, 32'h0102);
        tick(); check_eq("stall.pc2", {16'd0, PC}, 32'h0102);
        ex_valid = 1'b1; BrchOrJmpSig = 1'b1; brch_target = 16'hFFFE;
        tick();
        idle_inputs();
        check_eq("stalltake.pc", {16'd0, PC}, 32'hFFFE);
        check_eq("stalltake.cnt", {16'd0, redirect_cnt}, 32'h0003);
        tick(); check_eq("wrap.pc", {16'd0, PC}, 32'h0000);
        imem_busy = 1'b1;
        tick(); check_eq("busyhold.pc", {16'd0, PC}, 32'h0000);
        imem_busy = 1'b0;
        tick(); check_eq("busyrel.pc", {16'd0, PC}, 32'h0002);

        // Halt takes priority over a simultaneous take
        ex_valid = 1'b1; halt = 1'b1; BrchOrJmpSig = 1'b1; brch_target = 16'h0200;
        #1;
        check_flags("hlt.resolve", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        halt = 1'b0; brch_target = 16'h0300;
        check_eq("hlt.pc", {16'd0, PC}, 32'h0002);
        check_eq("hlt.cnt", {16'd0, redirect_cnt}, 32'h0003);
        check_flags("hlt", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        check_eq("hlt.pc_later", {16'd0, PC}, 32'h0002);
        check_eq("hlt.cnt_later", {16'd0, redirect_cnt}, 32'h0003);
        check_flags("hlt.later", 1'b0, 1'b0, 1'b0, 1'b1);
        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("hlt.rst_pc", {16'd0, PC}, 32'h0000);
        check_flags("hlt.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Counter saturation
        ex_valid = 1'b1; BrchOrJmpSig = 1'b1; brch_target = 16'h0400;
        repeat (65534) tick();
        check_eq("sat.fffe", {16'd0, redirect_cnt}, 32'hFFFE);
        tick();
        check_eq("sat.ffff", {16'd0, redirect_cnt}, 32'hFFFF);
        tick();
        check_eq("sat.hold", {16'd0, redirect_cnt}, 32'hFFFF);
        check_eq("sat.pc", {16'd0, PC}, 32'h0400);

        // Asynchronous reset during PEND
        brch_target = 16'h0500; imem_busy = 1'b1;
        tick();
        ex_valid = 1'b0; BrchOrJmpSig = 1'b0;
        #1;
        check_eq("midpend.pending", {31'd0, redirect_pending}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_flags("midpend.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("midpend.pc", {16'd0, PC}, 32'h0000);
        check_eq("midpend.cnt", {16'd0, redirect_cnt}, 32'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_busy = 1'b0;
        tick();
        check_eq("midpend.after_pc", {16'd0, PC}, 32'h0002);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
